// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-requester SRAM port arbiter.
package sram_arb_pkg;

    localparam int unsigned AW = 14;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    typedef enum logic {
        M0_IF,
        M1_LSU
    } master_e;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [SW-1:0] wstrb;
        logic [DW-1:0] wdata;
    } sram_req_t;

    typedef enum logic [1:0] {
        EMPTY,
        INFLIGHT,
        VALID,
        HELD
    } slot_state_e;

    // Byte enables to a per-bit mask (bit k covers bits [8k+7:8k]).
    function automatic logic [DW-1:0] expand_wstrb(input logic [SW-1:0] wstrb);
        logic [DW-1:0] mask;
        mask = '0;
        for (int k = 0; k < int'(SW); k++) begin
            mask[8*k +: 8] = {8{wstrb[k]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side request/response bundle; master = requester, slave = arbiter.
interface sram_port_arbiter_if;
    import sram_arb_pkg::*;

    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [SW-1:0] req_wstrb;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wstrb, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wstrb, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata
    );

endinterface

// File: rtl/sram_arb_resp_slot.sv
// One-deep read response slot: presents sram_q live, captures it if the requester stalls.
module sram_arb_resp_slot
    import sram_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          issue,
    input  logic          resp_ready,
    input  logic [DW-1:0] sram_q,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          free
);

    slot_state_e   state_q;
    logic          valid_q;
    logic [DW-1:0] hold_q;

    // The macro answers one edge after the access, so an accepted read lands straight in VALID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (issue) begin
                        state_q <= VALID;
                        valid_q <= 1'b1;
                    end
                end
                VALID: begin
                    if (resp_ready) begin
                        state_q <= issue ? VALID : EMPTY;
                        valid_q <= issue;
                    end else begin
                        state_q <= HELD;
                        hold_q  <= sram_q;
                    end
                end
                HELD: begin
                    if (resp_ready) begin
                        state_q <= issue ? VALID : EMPTY;
                        valid_q <= issue;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign resp_valid = valid_q;
    assign resp_rdata = (state_q == VALID) ? sram_q : hold_q;
    assign free       = (state_q == EMPTY) | (valid_q & resp_ready);

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter onto one single-port SRAM with m0 starvation bound.
// Define SRAM_ARB_PERF_EN to add saturating per-requester stall counters.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    sram_port_arbiter_if.slave  m0,
    sram_port_arbiter_if.slave  m1,
    output logic                sram_ceb,
    output logic                sram_web,
    output logic [AW-1:0]       sram_a,
    output logic [DW-1:0]       sram_bweb,
    output logic [DW-1:0]       sram_d,
    input  logic [DW-1:0]       sram_q
`ifdef SRAM_ARB_PERF_EN
    ,
    output logic [31:0]         perf_m0_stall,
    output logic [31:0]         perf_m1_stall
`endif
);

    localparam int unsigned SCW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

    logic [SCW-1:0] starve_q;
    logic           m0_free, m1_free;
    logic           m0_elig, m1_elig;
    logic           m0_wins;
    logic           gnt0, gnt1, gnt_any;
    master_e        gnt_sel;
    sram_req_t      m0_req, m1_req, req_sel;
    logic           m0_rv, m1_rv;
    logic [DW-1:0]  m0_rd, m1_rd;

    // Writes bypass the response slot entirely.
    assign m0_elig = m0.req_valid & (m0.req_we | m0_free);
    assign m1_elig = m1.req_valid & (m1.req_we | m1_free);
    assign m0_wins = m0_elig & (~m1_elig | (starve_q == STARVE_MAX));

    assign gnt0    = ~rst & m0_wins;
    assign gnt1    = ~rst & m1_elig & ~m0_wins;
    assign gnt_any = gnt0 | gnt1;
    assign gnt_sel = gnt1 ? M1_LSU : M0_IF;

    assign m0.req_ready = gnt0;
    assign m1.req_ready = gnt1;

    always_comb begin
        m0_req = '{we: m0.req_we, addr: m0.req_addr, wstrb: m0.req_wstrb, wdata: m0.req_wdata};
        m1_req = '{we: m1.req_we, addr: m1.req_addr, wstrb: m1.req_wstrb, wdata: m1.req_wdata};
        req_sel = (gnt_sel == M1_LSU) ? m1_req : m0_req;
    end

    always_comb begin
        sram_ceb  = 1'b1;
        sram_web  = 1'b1;
        sram_a    = '0;
        sram_bweb = '1;
        sram_d    = '0;
        if (gnt_any) begin
            sram_a = req_sel.addr;
            if (!req_sel.we) begin
                sram_ceb = 1'b0;
            end else if (|req_sel.wstrb) begin
                sram_ceb  = 1'b0;
                sram_web  = 1'b0;
                sram_bweb = ~expand_wstrb(req_sel.wstrb);
                sram_d    = req_sel.wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else if (!m0.req_valid || gnt0) begin
            starve_q <= '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_q <= starve_q + 1'b1;
        end
    end

    sram_arb_resp_slot u_slot_m0 (
        .clk        (clk),
        .rst        (rst),
        .issue      (gnt0 & ~m0.req_we),
        .resp_ready (m0.resp_ready),
        .sram_q     (sram_q),
        .resp_valid (m0_rv),
        .resp_rdata (m0_rd),
        .free       (m0_free)
    );

    sram_arb_resp_slot u_slot_m1 (
        .clk        (clk),
        .rst        (rst),
        .issue      (gnt1 & ~m1.req_we),
        .resp_ready (m1.resp_ready),
        .sram_q     (sram_q),
        .resp_valid (m1_rv),
        .resp_rdata (m1_rd),
        .free       (m1_free)
    );

    assign m0.resp_valid = m0_rv;
    assign m0.resp_rdata = m0_rd;
    assign m1.resp_valid = m1_rv;
    assign m1.resp_rdata = m1_rd;

`ifdef SRAM_ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_m0_stall <= '0;
            perf_m1_stall <= '0;
        end else begin
            if (m0.req_valid && !gnt0 && perf_m0_stall != '1) begin
                perf_m0_stall <= perf_m0_stall + 32'd1;
            end
            if (m1.req_valid && !gnt1 && perf_m1_stall != '1) begin
                perf_m1_stall <= perf_m1_stall + 32'd1;
            end
        end
    end
`endif

endmodule
